// File: rtl/register_file_dump.sv
// Two-read/one-write register file for the decode stage. A valid/ready dump engine
// streams every register in index order to the debug unit after a halt.
module register_file_dump #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              inicio,
   input  logic              activo,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD3,
   input  logic              WE3,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   input  logic              dump_start,
   input  logic              dump_ready,
   output logic              dump_valid,
   output logic [DATA_W-1:0] dump_data,
   output logic [ADDR_W-1:0] dump_idx,
   output logic              dump_busy,
   output logic              dump_done
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      DONE
   } dump_state_e;

   logic [DATA_W-1:0] bank_q [DEPTH];
   logic [DATA_W-1:0] bank_d [DEPTH];

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // A write that survives the register-0 rule; also qualifies the bypass path.
   logic wr_keep;
   assign wr_keep = WE3 && activo && !(ZERO_REG && (A3 == '0));

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      bank_d = bank_q;
      if (wr_keep) begin
         bank_d[A3] = WD3;
      end
   end

   always_comb begin
      RD1 = bank_q[A1];
      if (ZERO_REG && (A1 == '0)) begin
         RD1 = '0;
      end
      if (BYPASS && wr_keep && (A3 == A1)) begin
         RD1 = WD3;
      end

      RD2 = bank_q[A2];
      if (ZERO_REG && (A2 == '0)) begin
         RD2 = '0;
      end
      if (BYPASS && wr_keep && (A3 == A2)) begin
         RD2 = WD3;
      end
   end

   // Dump engine: one LOAD cycle snapshots the word, SEND holds it until accepted.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;

      unique case (state_q)
         IDLE: begin
            if (dump_start) begin
               idx_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            data_d  = (ZERO_REG && (idx_q == '0)) ? '0 : bank_q[idx_q];
            state_d = SEND;
         end
         SEND: begin
            if (dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = LOAD;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered copies of the next state so they align with it.
      valid_d = (state_d == SEND);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (inicio) begin
         // NOTE: the bank is cleared on reset because the architectural state must read
         // zero afterwards; a plain storage array would normally be left unreset.
         for (int i = 0; i < DEPTH; i++) begin
            bank_q[i] <= '0;
         end
         state_q <= IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples
         // values from before the edge, independent of statement order.
         bank_q  <= bank_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign dump_valid = valid_q;
   assign dump_data  = data_q;
   assign dump_idx   = idx_q;
   assign dump_busy  = busy_q;
   assign dump_done  = done_q;

endmodule

// File: tb/tb_register_file_dump.sv
// Directed bench for register_file_dump. Dump words are scoreboarded through a queue
// that a negedge monitor drains. An alternate instance covers ZERO_REG=0 and BYPASS=0.
module tb_register_file_dump;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   logic              clk = 1'b0;
   logic              inicio;
   logic              activo;
   logic [ADDR_W-1:0] A1, A2, A3;
   logic [DATA_W-1:0] WD3;
   logic              WE3;
   logic [DATA_W-1:0] rd1, rd2, rd1_alt, rd2_alt;
   logic              dump_start, dump_ready;
   logic              dump_valid, dump_busy, dump_done;
   logic [DATA_W-1:0] dump_data;
   logic [ADDR_W-1:0] dump_idx;
   logic              alt_valid, alt_busy, alt_done;
   logic [DATA_W-1:0] alt_data;
   logic [ADDR_W-1:0] alt_idx;

   always #5 clk = ~clk;

   register_file_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .inicio(inicio), .activo(activo), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
      .WE3(WE3), .RD1(rd1), .RD2(rd2), .dump_start(dump_start), .dump_ready(dump_ready),
      .dump_valid(dump_valid), .dump_data(dump_data), .dump_idx(dump_idx),
      .dump_busy(dump_busy), .dump_done(dump_done)
   );

   register_file_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_alt (
      .clk(clk), .inicio(inicio), .activo(activo), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
      .WE3(WE3), .RD1(rd1_alt), .RD2(rd2_alt), .dump_start(1'b0), .dump_ready(dump_ready),
      .dump_valid(alt_valid), .dump_data(alt_data), .dump_idx(alt_idx),
      .dump_busy(alt_busy), .dump_done(alt_done)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
   } word_t;

   word_t             exp_q[$];
   logic [DATA_W-1:0] model [DEPTH];
   int                errors   = 0;
   int                checks   = 0;
   int                done_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected word per accepted handshake and checks stall stability.
   logic              hold_v = 1'b0;
   logic [ADDR_W-1:0] hold_idx;
   logic [DATA_W-1:0] hold_data;
   word_t             got;

   always @(negedge clk) begin
      if (hold_v) begin
         check("stall_valid", 64'(dump_valid), 64'd1);
         check("stall_idx", 64'(dump_idx), 64'(hold_idx));
         check("stall_data", 64'(dump_data), 64'(hold_data));
      end
      hold_v    = dump_valid && !dump_ready && !inicio;
      hold_idx  = dump_idx;
      hold_data = dump_data;
      if (dump_valid && dump_ready && !inicio) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(dump_idx), 64'hFFFF);
         end else begin
            got = exp_q.pop_front();
            check("dump_idx", 64'(dump_idx), 64'(got.idx));
            check("dump_data", 64'(dump_data), 64'(got.data));
         end
      end
      if (dump_done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      A3 = a; WD3 = d; WE3 = 1'b1; activo = 1'b1;
      tick();
      WE3 = 1'b0;
      if (a != '0) model[a] = d;
   endtask

   task automatic push_dump();
      for (int k = 0; k < DEPTH; k++) begin
         exp_q.push_back({5'(k), model[k]});
      end
   endtask

   task automatic wait_done(input int base, input int bound);
      int n = 0;
      while (done_cnt == base && n < bound) begin
         tick();
         n++;
      end
      check("dump_done_seen", 64'(done_cnt != base), 64'd1);
   endtask

   task automatic check_all_zero();
      for (int a = 0; a < DEPTH; a++) begin
         A1 = 5'(a); A2 = 5'(DEPTH - 1 - a);
         #1;
         check("rst_rd1", 64'(rd1), 64'd0);
         check("rst_rd2", 64'(rd2), 64'd0);
         check("rst_rd1_alt", 64'(rd1_alt), 64'd0);
      end
   endtask

   logic [15:0] pat = 16'b1011_0010_1101_0110;
   int first_v, done_n, stall, base, n;

   initial begin
      inicio = 1'b1; activo = 1'b1; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
      dump_start = 1'b0; dump_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) model[k] = '0;
      tick(); tick();
      check("rst_busy", 64'(dump_busy), 64'd0);
      check("rst_valid", 64'(dump_valid), 64'd0);
      check("rst_done", 64'(dump_done), 64'd0);
      check("rst_idx", 64'(dump_idx), 64'd0);
      check("rst_data", 64'(dump_data), 64'd0);
      inicio = 1'b0;

      // Writes followed by a reset that also carries a write, which must be discarded.
      wr(5'd1, 32'h1111_0001); wr(5'd9, 32'h9999_0009); wr(5'd31, 32'hFFFF_001F);
      inicio = 1'b1; A3 = 5'd4; WD3 = 32'h4444_4444; WE3 = 1'b1;
      tick();
      inicio = 1'b0; WE3 = 1'b0;
      for (int k = 0; k < DEPTH; k++) model[k] = '0;
      check_all_zero();
      check("rst2_busy", 64'(dump_busy), 64'd0);
      check("rst2_valid", 64'(dump_valid), 64'd0);

      // Same-cycle write and read of r5.
      A1 = 5'd5; A2 = 5'd5; A3 = 5'd5; WD3 = 32'hDEAD_BEEF; WE3 = 1'b1; activo = 1'b1;
      #1;
      check("byp_rd1", 64'(rd1), 64'hDEAD_BEEF);
      check("byp_rd2", 64'(rd2), 64'hDEAD_BEEF);
      check("nobyp_rd1_same", 64'(rd1_alt), 64'd0);
      check("nobyp_rd2_same", 64'(rd2_alt), 64'd0);
      tick();
      WE3 = 1'b0; model[5] = 32'hDEAD_BEEF;
      #1;
      check("nobyp_rd1_next", 64'(rd1_alt), 64'hDEAD_BEEF);
      check("nobyp_rd2_next", 64'(rd2_alt), 64'hDEAD_BEEF);
      check("byp_rd1_next", 64'(rd1), 64'hDEAD_BEEF);

      // activo=0 drops the write and suppresses the bypass.
      A1 = 5'd6; A3 = 5'd6; WD3 = 32'hCAFE_F00D; WE3 = 1'b1; activo = 1'b0;
      #1;
      check("stall_byp_rd1", 64'(rd1), 64'd0);
      tick();
      WE3 = 1'b0; activo = 1'b1;
      #1;
      check("stall_wr_lost", 64'(rd1), 64'd0);
      check("stall_wr_lost_alt", 64'(rd1_alt), 64'd0);

      // Register 0: hardwired zero in the main instance, ordinary in the alternate.
      A1 = 5'd0; A3 = 5'd0; WD3 = 32'h1234_5678; WE3 = 1'b1;
      #1;
      check("r0_same_main", 64'(rd1), 64'd0);
      check("r0_same_alt", 64'(rd1_alt), 64'd0);
      tick();
      WE3 = 1'b0;
      #1;
      check("r0_next_main", 64'(rd1), 64'd0);
      check("r0_next_alt", 64'(rd1_alt), 64'h1234_5678);

      // Full dump with ready held high: rk = k*0x11, word 0 reads as zero.
      for (int k = 1; k < DEPTH; k++) wr(5'(k), 32'(k * 32'h11));
      dump_ready = 1'b1; dump_start = 1'b1;
      push_dump();
      first_v = -1; done_n = -1;
      for (int c = 1; c <= 200 && done_n < 0; c++) begin
         tick();
         dump_start = 1'b0;
         if (c == 1) check("busy_in_load", 64'(dump_busy), 64'd1);
         if (dump_valid && first_v < 0) first_v = c;
         if (dump_done) done_n = c;
      end
      check("first_valid_cycle", 64'(first_v), 64'd2);
      check("done_cycle", 64'(done_n), 64'd65);
      tick();
      check("done_one_cycle", 64'(dump_done), 64'd0);
      check("busy_after_done", 64'(dump_busy), 64'd0);
      check("full_queue_empty", 64'(exp_q.size()), 64'd0);

      // Backpressure, with r3 rewritten while word 3 waits in SEND.
      base = done_cnt; stall = 0;
      dump_start = 1'b1; dump_ready = pat[0];
      push_dump();
      tick();
      dump_start = 1'b0;
      for (int c = 1; c < 600 && done_cnt == base; c++) begin
         if (dump_valid && dump_idx == 5'd3 && stall < 3) begin
            dump_ready = 1'b0;
            if (stall == 0) begin
               A3 = 5'd3; WD3 = 32'hABCD_0003; WE3 = 1'b1; activo = 1'b1;
            end else begin
               WE3 = 1'b0;
            end
            stall++;
         end else begin
            WE3 = 1'b0;
            dump_ready = pat[c % 16];
         end
         tick();
      end
      WE3 = 1'b0; model[3] = 32'hABCD_0003;
      check("bp_done", 64'(done_cnt), 64'(base + 1));
      check("bp_stalled_on_3", 64'(stall), 64'd3);
      check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
      A1 = 5'd3;
      #1;
      check("r3_updated", 64'(rd1), 64'hABCD_0003);

      // Restart request mid-dump is ignored; reset at word 10 aborts without dump_done.
      tick();
      base = done_cnt; dump_ready = 1'b1; dump_start = 1'b1;
      push_dump();
      tick();
      dump_start = 1'b0; n = 0;
      while (!(dump_valid && dump_idx == 5'd10) && n < 200) begin
         dump_start = (n == 6);
         tick();
         n++;
      end
      dump_start = 1'b0;
      check("reached_word10", 64'(dump_idx), 64'd10);
      inicio = 1'b1; dump_ready = 1'b0;
      A3 = 5'd7; WD3 = 32'h7777_7777; WE3 = 1'b1;
      #1;
      check("words_left_at_abort", 64'(exp_q.size()), 64'd22);
      tick();
      inicio = 1'b0; WE3 = 1'b0;
      exp_q.delete();
      for (int k = 0; k < DEPTH; k++) model[k] = '0;
      check("abort_busy", 64'(dump_busy), 64'd0);
      check("abort_valid", 64'(dump_valid), 64'd0);
      check("abort_idx", 64'(dump_idx), 64'd0);
      check("abort_data", 64'(dump_data), 64'd0);
      tick(); tick(); tick();
      check("abort_no_done", 64'(done_cnt), 64'(base));
      check_all_zero();

      // Fresh dump after the abort starts again from index 0.
      dump_ready = 1'b1; dump_start = 1'b1;
      push_dump();
      tick();
      dump_start = 1'b0;
      wait_done(base, 200);
      tick();
      check("post_abort_queue_empty", 64'(exp_q.size()), 64'd0);
      check("alt_never_busy", 64'(alt_busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
